// File: rtl/ram_lsu_if.sv
// rtl/ram_lsu_if.sv - CPU-side load/store request bus between the memory stage and ram_lsu
interface ram_lsu_if #(
    parameter int ADDR_W = 10
) ();
    logic              req;
    logic              wr;
    logic [1:0]        size;
    logic              unsigned_ld;
    logic [ADDR_W+1:0] addr;
    logic [31:0]       wdata;
    logic [31:0]       rdata;
    logic              busy;
    logic              done;
    logic              err;

    modport master (
        output req, wr, size, unsigned_ld, addr, wdata,
        input  rdata, busy, done, err
    );

    modport slave (
        input  req, wr, size, unsigned_ld, addr, wdata,
        output rdata, busy, done, err
    );
endinterface

// File: rtl/ram_lsu.sv
// rtl/ram_lsu.sv - byte/halfword/word load-store initiator for a word-organised RAM
// Sub-word stores are read-modify-write; loads are sign or zero extended.
module ram_lsu #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    ram_lsu_if.slave          bus,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_d,
    output logic              ram_we,
    input  logic [31:0]       ram_q
);
    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        WRITE,
        DONE
    } state_t;

    state_t      state;
    logic        wr_q;
    logic [1:0]  size_q;
    logic        uns_q;
    logic [1:0]  off_q;
    logic [31:0] wdata_q;
    logic        misaligned;

    // Little-endian lane select followed by extension to 32 bits.
    function automatic logic [31:0] load_extract(
        input logic [31:0] word,
        input logic [1:0]  size,
        input logic [1:0]  off,
        input logic        uns
    );
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (off)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        h = off[1] ? word[31:16] : word[15:0];
        case (size)
            2'b00:   r = uns ? {24'h0, b} : {{24{b[7]}}, b};
            2'b01:   r = uns ? {16'h0, h} : {{16{h[15]}}, h};
            default: r = word;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] store_merge(
        input logic [31:0] word,
        input logic [31:0] wd,
        input logic [1:0]  size,
        input logic [1:0]  off
    );
        logic [31:0] r;
        r = word;
        case (size)
            2'b00: begin
                case (off)
                    2'd0:    r[7:0]   = wd[7:0];
                    2'd1:    r[15:8]  = wd[7:0];
                    2'd2:    r[23:16] = wd[7:0];
                    default: r[31:24] = wd[7:0];
                endcase
            end
            2'b01: begin
                if (off[1]) r[31:16] = wd[15:0];
                else        r[15:0]  = wd[15:0];
            end
            default: r = wd;
        endcase
        return r;
    endfunction

    always_comb begin
        misaligned = 1'b0;
        case (bus.size)
            2'b01:   misaligned = bus.addr[0];
            2'b10:   misaligned = |bus.addr[1:0];
            2'b11:   misaligned = 1'b1;
            default: misaligned = 1'b0;
        endcase
    end

    // Write strobe is gated by rst directly so a reset landing in WRITE cannot commit a partial store.
    assign ram_we = (state == WRITE) & ~rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            bus.rdata <= 32'h0;
            bus.busy  <= 1'b0;
            bus.done  <= 1'b0;
            bus.err   <= 1'b0;
            ram_addr  <= '0;
            ram_d     <= 32'h0;
            wr_q      <= 1'b0;
            size_q    <= 2'b00;
            uns_q     <= 1'b0;
            off_q     <= 2'b00;
            wdata_q   <= 32'h0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.req) begin
                        wr_q     <= bus.wr;
                        size_q   <= bus.size;
                        uns_q    <= bus.unsigned_ld;
                        off_q    <= bus.addr[1:0];
                        wdata_q  <= bus.wdata;
                        ram_addr <= bus.addr[ADDR_W+1:2];
                        bus.busy <= 1'b1;
                        if (misaligned) begin
                            state    <= DONE;
                            bus.err  <= 1'b1;
                            bus.done <= 1'b1;
                        end else begin
                            state <= ACCESS;
                        end
                    end
                end
                ACCESS: begin
                    if (wr_q) begin
                        ram_d <= store_merge(ram_q, wdata_q, size_q, off_q);
                        state <= WRITE;
                    end else begin
                        bus.rdata <= load_extract(ram_q, size_q, off_q, uns_q);
                        bus.done  <= 1'b1;
                        state     <= DONE;
                    end
                end
                WRITE: begin
                    bus.done <= 1'b1;
                    state    <= DONE;
                end
                default: begin
                    bus.busy <= 1'b0;
                    bus.err  <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ram_lsu.sv
// tb/tb_ram_lsu.sv - scoreboard bench for ram_lsu with a behavioural word RAM
module tb_ram_lsu;
    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  ram_addr;
    logic [31:0] ram_d;
    logic        ram_we;
    logic [31:0] ram_q;
    logic [31:0] mem [0:1023];

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          cyc;
    } exp_t;

    typedef struct {
        logic [9:0]  addr;
        logic [31:0] d;
        int          cyc;
    } wexp_t;

    exp_t  exp_q[$];
    wexp_t wq[$];
    exp_t  me;
    wexp_t mw;

    ram_lsu_if #(.ADDR_W(10)) bus ();

    ram_lsu #(.ADDR_W(10)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .ram_addr (ram_addr),
        .ram_d    (ram_d),
        .ram_we   (ram_we),
        .ram_q    (ram_q)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign ram_q = mem[ram_addr];
    always @(posedge clk) if (ram_we) mem[ram_addr] = ram_d;

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // Monitor: observed cycle number is edges-so-far + 1 (the period after edge N is cycle N+1).
    always @(negedge clk) begin
        if (bus.done) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 at cycle %0d expected none", cyc + 1);
            end else begin
                me = exp_q.pop_front();
                chk1("done_err", bus.err, me.err);
                chk32("done_rdata", bus.rdata, me.rdata);
                chk32("done_cycle", cyc + 1, me.cyc);
            end
        end else if (bus.err) begin
            checks++;
            errors++;
            $display("FAIL err_without_done: got err=1 expected 0");
        end
        if (ram_we) begin
            if (wq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_we: got ram_we=1 addr %h expected none", ram_addr);
            end else begin
                mw = wq.pop_front();
                chk32("we_addr", {22'h0, ram_addr}, {22'h0, mw.addr});
                chk32("we_data", ram_d, mw.d);
                chk32("we_cycle", cyc + 1, mw.cyc);
            end
        end
    end

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || wq.size() != 0) && n < 30) begin
            @(negedge clk);
            #1;
            n++;
        end
        checks++;
        if (exp_q.size() != 0 || wq.size() != 0) begin
            errors++;
            $display("FAIL timeout: got %0d pending responses expected 0", exp_q.size() + wq.size());
            exp_q.delete();
            wq.delete();
        end
    endtask

    // Issue one request; hold>0 keeps a conflicting req asserted for that many cycles while busy.
    task automatic issue(input logic w, input logic [1:0] sz, input logic uns,
                         input logic [11:0] a, input logic [31:0] wd,
                         input logic e_err, input logic [31:0] e_rdata,
                         input logic [9:0] e_waddr, input logic [31:0] e_wd, input int hold);
        exp_t  e;
        wexp_t x;
        int    acc;
        @(negedge clk);
        bus.req = 1'b1;
        bus.wr = w;
        bus.size = sz;
        bus.unsigned_ld = uns;
        bus.addr = a;
        bus.wdata = wd;
        acc = cyc + 1;
        e.err = e_err;
        e.rdata = e_rdata;
        e.cyc = acc + (e_err ? 1 : (w ? 3 : 2));
        exp_q.push_back(e);
        if (w && !e_err) begin
            x.addr = e_waddr;
            x.d = e_wd;
            x.cyc = acc + 2;
            wq.push_back(x);
        end
        @(posedge clk);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            bus.req = 1'b1;
            bus.wr = 1'b1;
            bus.size = 2'b10;
            bus.addr = 12'h040;
            bus.wdata = 32'h5555AAAA;
        end
        @(negedge clk);
        bus.req = 1'b0;
        drain();
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        mem[5]  = 32'h8899AABB;
        mem[12] = 32'h11223344;
        rst = 1'b1;
        bus.req = 1'b0;
        bus.wr = 1'b0;
        bus.size = 2'b00;
        bus.unsigned_ld = 1'b0;
        bus.addr = 12'h0;
        bus.wdata = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk32("rst_rdata", bus.rdata, 32'h0);
        chk32("rst_ram_d", ram_d, 32'h0);
        chk32("rst_ram_addr", {22'h0, ram_addr}, 32'h0);
        chk1("rst_busy", bus.busy, 1'b0);
        chk1("rst_done", bus.done, 1'b0);
        chk1("rst_err", bus.err, 1'b0);
        chk1("rst_we", ram_we, 1'b0);
        rst = 1'b0;

        //    wr    size   uns   addr     wdata         err   rdata         waddr  wd            hold
        issue(1'b0, 2'b00, 1'b0, 12'h016, 32'h0,        1'b0, 32'hFFFFFF99, 10'd0, 32'h0,        0);
        issue(1'b0, 2'b00, 1'b1, 12'h016, 32'h0,        1'b0, 32'h00000099, 10'd0, 32'h0,        0);
        issue(1'b1, 2'b01, 1'b0, 12'h016, 32'h1234CAFE, 1'b0, 32'h00000099, 10'd5, 32'hCAFEAABB, 0);
        issue(1'b0, 2'b10, 1'b0, 12'h014, 32'h0,        1'b0, 32'hCAFEAABB, 10'd0, 32'h0,        0);
        issue(1'b1, 2'b10, 1'b0, 12'h020, 32'hDEADBEEF, 1'b0, 32'hCAFEAABB, 10'd8, 32'hDEADBEEF, 0);
        issue(1'b0, 2'b00, 1'b0, 12'h023, 32'h0,        1'b0, 32'hFFFFFFDE, 10'd0, 32'h0,        0);
        issue(1'b0, 2'b01, 1'b0, 12'h013, 32'h0,        1'b1, 32'hFFFFFFDE, 10'd0, 32'h0,        0);
        issue(1'b0, 2'b10, 1'b0, 12'h022, 32'h0,        1'b1, 32'hFFFFFFDE, 10'd0, 32'h0,        0);
        issue(1'b0, 2'b11, 1'b0, 12'h020, 32'h0,        1'b1, 32'hFFFFFFDE, 10'd0, 32'h0,        0);
        issue(1'b1, 2'b01, 1'b0, 12'h033, 32'h0000BEEF, 1'b1, 32'hFFFFFFDE, 10'd0, 32'h0,        0);

        // Reset landing in the WRITE cycle of a byte store.
        @(negedge clk);
        bus.req = 1'b1;
        bus.wr = 1'b1;
        bus.size = 2'b00;
        bus.addr = 12'h031;
        bus.wdata = 32'h000000A5;
        @(posedge clk);
        @(negedge clk);
        bus.req = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk1("midrst_busy", bus.busy, 1'b1);
        chk1("midrst_we", ram_we, 1'b0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk1("postrst_busy", bus.busy, 1'b0);
        chk1("postrst_done", bus.done, 1'b0);
        chk32("postrst_rdata", bus.rdata, 32'h0);
        chk32("postrst_ram_d", ram_d, 32'h0);
        chk32("postrst_ram_addr", {22'h0, ram_addr}, 32'h0);
        chk32("postrst_mem12", mem[12], 32'h11223344);
        repeat (4) @(negedge clk);

        issue(1'b0, 2'b10, 1'b0, 12'h030, 32'h0,        1'b0, 32'h11223344, 10'd0,  32'h0,        0);
        issue(1'b1, 2'b00, 1'b0, 12'h031, 32'h000000A5, 1'b0, 32'h11223344, 10'd12, 32'h1122A544, 3);
        repeat (8) @(negedge clk);
        chk32("busy_mem16", mem[16], 32'h0);
        chk32("busy_mem12", mem[12], 32'h1122A544);
        chk1("final_busy", bus.busy, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
